// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the multi-digit stopwatch: FSM states,
// 7-segment encoding and per-digit radix.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SET  = 2'd2
    } state_e;

    // Active-low gfedcba; anything above 9 blanks the digit.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] radix(input int i);
        return (i == 3 || i == 5) ? 4'd6 : 4'd10;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus stability counter for one active-low button;
// emits a single-cycle pulse once a press has been stable for CYCLES cycles.
module button_debouncer #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk100_i,
    input  logic rstn_i,
    input  logic btn_ni,
    output logic press_o
);

    localparam int unsigned   CW   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any bounce back restarts qualification from zero.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_ni;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_multi.sv
// Multi-digit stopwatch: debounced buttons, IDLE/RUN/SET control, prescaled
// mixed-radix counter, lap freeze, sticky overflow and registered segments.
module stopwatch_multi
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk100_i,
    input  logic                  rstn_i,
    input  logic                  start_stop_i,
    input  logic                  set_i,
    input  logic                  change_i,
    input  logic                  lap_i,
    output logic [7*DIGITS-1:0]   hex_o,
    output logic [DIGITS-1:0]     sel_o,
    output logic                  running_o,
    output logic                  set_mode_o,
    output logic                  overflow_o
);

    localparam int unsigned   DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int unsigned   PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
    localparam int unsigned   DW    = $clog2(DIGITS);
    localparam logic [DW-1:0] DLAST = DW'(DIGITS - 1);

    logic ev_ss, ev_set, ev_chg, ev_lap;
    logic do_set, do_ss, do_chg, do_lap;

    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_ss  (.clk100_i(clk100_i), .rstn_i(rstn_i), .btn_ni(start_stop_i), .press_o(ev_ss));
    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_set (.clk100_i(clk100_i), .rstn_i(rstn_i), .btn_ni(set_i),        .press_o(ev_set));
    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_chg (.clk100_i(clk100_i), .rstn_i(rstn_i), .btn_ni(change_i),     .press_o(ev_chg));
    button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_lap (.clk100_i(clk100_i), .rstn_i(rstn_i), .btn_ni(lap_i),        .press_o(ev_lap));

    // Only the highest-priority event of a cycle is acted upon.
    assign do_set = ev_set;
    assign do_ss  = ev_ss  & ~ev_set;
    assign do_chg = ev_chg & ~ev_set & ~ev_ss;
    assign do_lap = ev_lap & ~ev_set & ~ev_ss & ~ev_chg;

    state_e                   state_q, state_d;
    logic [DW-1:0]            dig_q, dig_d;
    logic                     freeze_q, freeze_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic [DIGITS-1:0][3:0]   cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic [7*DIGITS-1:0]      hex_q, hex_d;
    logic                     tick, clear, edit, carry;

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        freeze_d = freeze_q;
        clear    = 1'b0;
        edit     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (do_set) begin
                    state_d = SET;
                    dig_d   = '0;
                end else if (do_ss) begin
                    state_d = RUN;
                end else if (do_chg) begin
                    clear = 1'b1;
                end
            end
            RUN: begin
                if (do_set) begin
                    state_d  = SET;
                    dig_d    = '0;
                    freeze_d = 1'b0;
                end else if (do_ss) begin
                    state_d  = IDLE;
                    freeze_d = 1'b0;
                end else if (do_lap) begin
                    freeze_d = ~freeze_q;
                end
            end
            SET: begin
                if (do_set) begin
                    if (dig_q == DLAST) begin
                        state_d = IDLE;
                        dig_d   = '0;
                    end else begin
                        dig_d = dig_q + 1'b1;
                    end
                end else if (do_chg) begin
                    edit = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler idles at zero outside RUN, so entering RUN starts a full period.
    assign tick = (state_q == RUN) && (presc_q == PLAST);

    always_comb begin
        presc_d = '0;
        if (state_q == RUN && !tick) presc_d = presc_q + 1'b1;
    end

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        carry = 1'b0;
        if (tick) begin
            carry = 1'b1;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (cnt_q[i] == radix(int'(i)) - 4'd1) begin
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                        carry    = 1'b0;
                    end
                end
            end
            if (carry) ovf_d = 1'b1;
        end else if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (edit) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (dig_q == DW'(i))
                    cnt_d[i] = (cnt_q[i] == radix(int'(i)) - 4'd1) ? 4'd0 : cnt_q[i] + 4'd1;
            end
        end
    end

    // While frozen the segment register simply stops loading.
    always_comb begin
        hex_d = hex_q;
        if (!freeze_q) begin
            for (int unsigned i = 0; i < DIGITS; i++) hex_d[7*i +: 7] = seg7(cnt_q[i]);
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            dig_q    <= '0;
            freeze_q <= 1'b0;
            presc_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            hex_q    <= {DIGITS{7'h40}};
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            freeze_q <= freeze_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            hex_q    <= hex_d;
        end
    end

    always_comb begin
        sel_o = '0;
        if (state_q == SET) begin
            for (int unsigned i = 0; i < DIGITS; i++) sel_o[i] = (dig_q == DW'(i));
        end
    end

    assign hex_o      = hex_q;
    assign running_o  = (state_q == RUN);
    assign set_mode_o = (state_q == SET);
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_stopwatch_multi.sv
// Scoreboard bench for stopwatch_multi (1 kHz clock, 100 Hz tick, 6 digits,
// 4-cycle debounce): stimulus queues expectations, a monitor compares them.
module tb_stopwatch_multi;

    localparam int B_SS  = 1;
    localparam int B_SET = 2;
    localparam int B_CHG = 4;
    localparam int B_LAP = 8;
    localparam int MOD   = 360000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ss_n, set_n, chg_n, lap_n;
    logic [41:0] hex;
    logic [5:0]  sel;
    logic        running, setm, ovf;

    always #5 clk = ~clk;

    stopwatch_multi #(
        .CLK_FREQ_HZ(1000),
        .TICK_HZ(100),
        .DIGITS(6),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk100_i(clk),
        .rstn_i(rstn),
        .start_stop_i(ss_n),
        .set_i(set_n),
        .change_i(chg_n),
        .lap_i(lap_n),
        .hex_o(hex),
        .sel_o(sel),
        .running_o(running),
        .set_mode_o(setm),
        .overflow_o(ovf)
    );

    typedef struct {
        string       name;
        logic [41:0] hex;
        logic        run;
        logic        setm;
        logic        ovf;
        logic [5:0]  sel;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_evt = 0;
    int   mv       = 0;
    int   R, S, F, frozen;

    logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            n_checks++;
            if ({hex, running, setm, ovf, sel} === {cur.hex, cur.run, cur.setm, cur.ovf, cur.sel})
                n_pass++;
            else
                $display("FAIL %s: got hex=%h run=%b set=%b ovf=%b sel=%b, expected hex=%h run=%b set=%b ovf=%b sel=%b",
                         cur.name, hex, running, setm, ovf, sel,
                         cur.hex, cur.run, cur.setm, cur.ovf, cur.sel);
        end
    end

    function automatic int rdx(input int i);
        return (i == 3 || i == 5) ? 6 : 10;
    endfunction

    function automatic int digit_of(input int v, input int i);
        int t = v;
        for (int j = 0; j < i; j++) t = t / rdx(j);
        return t % rdx(i);
    endfunction

    function automatic logic [41:0] enc(input int v);
        logic [41:0] h = '0;
        for (int i = 0; i < 6; i++) h[7*i +: 7] = SEG[digit_of(v, i)];
        return h;
    endfunction

    function automatic int weight(input int i);
        int w = 1;
        for (int j = 0; j < i; j++) w = w * rdx(j);
        return w;
    endfunction

    task automatic expect_st(input string name, input logic [41:0] h, input logic r,
                             input logic s, input logic o, input logic [5:0] sl);
        exp_t e;
        e.name = name; e.hex = h; e.run = r; e.setm = s; e.ovf = o; e.sel = sl;
        sbq.push_back(e);
    endtask

    task automatic drive(input int mask, input logic lvl);
        if (mask & B_SS)  ss_n  = lvl;
        if (mask & B_SET) set_n = lvl;
        if (mask & B_CHG) chg_n = lvl;
        if (mask & B_LAP) lap_n = lvl;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pin low for 6 cycles; the resulting state change lands on edge start+7.
    task automatic press(input int mask);
        last_evt = cyc + 7;
        drive(mask, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        drive(mask, 1'b1);
    endtask

    task automatic settle();
        wait_to(last_evt + 6);
    endtask

    task automatic tap(input int mask);
        press(mask);
        settle();
    endtask

    task automatic preset_to(input int target);
        int n;
        tap(B_SET);
        for (int i = 0; i < 6; i++) begin
            n = (digit_of(target, i) - digit_of(mv, i) + rdx(i)) % rdx(i);
            repeat (n) tap(B_CHG);
            tap(B_SET);
        end
        mv = target;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete, expected completion before timeout");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        ss_n = 1'b1; set_n = 1'b1; chg_n = 1'b1; lap_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_st("reset", {6{7'h40}}, 1'b0, 1'b0, 1'b0, 6'b0);
        n_checks++;
        if (hex === {6{7'h40}} && running === 1'b0 && ovf === 1'b0)
            n_pass++;
        else
            $display("FAIL reset_direct: got hex=%h run=%b ovf=%b, expected hex=%h run=0 ovf=0",
                     hex, running, ovf, {6{7'h40}});
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 3-cycle glitch must be rejected
        drive(B_SS, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        drive(B_SS, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        expect_st("glitch", {6{7'h40}}, 1'b0, 1'b0, 1'b0, 6'b0);
        n_checks++;
        if (running === 1'b0 && hex === {6{7'h40}})
            n_pass++;
        else
            $display("FAIL glitch_direct: got run=%b hex=%h, expected run=0 hex=%h",
                     running, hex, {6{7'h40}});

        press(B_SS);
        expect_st("pre_edge", {6{7'h40}}, 1'b0, 1'b0, 1'b0, 6'b0);
        @(posedge clk);
        #1;
        expect_st("run_at_7", {6{7'h40}}, 1'b1, 1'b0, 1'b0, 6'b0);
        n_checks++;
        if (running === 1'b1 && setm === 1'b0)
            n_pass++;
        else
            $display("FAIL run_at_7_direct: got run=%b set=%b, expected run=1 set=0",
                     running, setm);
        R = last_evt;
        settle();

        wait_to(R + 1235);
        expect_st("count_123", enc(123), 1'b1, 1'b0, 1'b0, 6'b0);
        press(B_SS);
        S = last_evt;
        settle();
        mv = (S - R) / 10;
        expect_st("stopped", enc(mv), 1'b0, 1'b0, 1'b0, 6'b0);

        tap(B_CHG);
        mv = 0;
        expect_st("clear_idle", enc(0), 1'b0, 1'b0, 1'b0, 6'b0);

        tap(B_SET);
        expect_st("set_enter", enc(0), 1'b0, 1'b1, 1'b0, 6'b000001);
        repeat (9) tap(B_CHG);
        expect_st("set_d0_9", enc(9), 1'b0, 1'b1, 1'b0, 6'b000001);
        tap(B_SET);
        repeat (8) tap(B_CHG);
        expect_st("set_d1_8", enc(89), 1'b0, 1'b1, 1'b0, 6'b000010);
        tap(B_SET);
        tap(B_SET);
        tap(B_SS);
        tap(B_LAP);
        expect_st("set_ignore", enc(89), 1'b0, 1'b1, 1'b0, 6'b001000);
        repeat (7) tap(B_CHG);
        mv = 89 + 1 * weight(3);
        expect_st("set_d3_mod6", enc(mv), 1'b0, 1'b1, 1'b0, 6'b001000);
        repeat (3) tap(B_SET);
        expect_st("set_exit", enc(mv), 1'b0, 1'b0, 1'b0, 6'b0);

        preset_to(MOD - 1);
        expect_st("preset_max", enc(MOD - 1), 1'b0, 1'b0, 1'b0, 6'b0);
        press(B_SS);
        R = last_evt;
        settle();
        wait_to(R + 15);
        expect_st("wrap", enc(0), 1'b1, 1'b0, 1'b1, 6'b0);
        press(B_SS);
        S = last_evt;
        settle();
        mv = (mv + (S - R) / 10) % MOD;
        expect_st("wrap_stop", enc(mv), 1'b0, 1'b0, 1'b1, 6'b0);
        tap(B_CHG);
        mv = 0;
        expect_st("clear_ovf", enc(0), 1'b0, 1'b0, 1'b0, 6'b0);

        press(B_SS);
        R = last_evt;
        settle();
        wait_to(R + 98);
        press(B_LAP);
        F = last_evt;
        settle();
        frozen = (F - 1 - R) / 10;
        wait_to(R + 205);
        expect_st("lap_frozen", enc(frozen), 1'b1, 1'b0, 1'b0, 6'b0);
        wait_to(R + 298);
        press(B_LAP);
        wait_to(R + 307);
        expect_st("lap_live", enc((cyc - 1 - R) / 10), 1'b1, 1'b0, 1'b0, 6'b0);
        settle();
        press(B_LAP);
        F = last_evt;
        settle();
        frozen = (F - 1 - R) / 10;
        expect_st("lap_refrozen", enc(frozen), 1'b1, 1'b0, 1'b0, 6'b0);
        press(B_SS);
        S = last_evt;
        settle();
        mv = (S - R) / 10;
        expect_st("lap_stop_clear", enc(mv), 1'b0, 1'b0, 1'b0, 6'b0);
        tap(B_LAP);
        tap(B_CHG);
        mv = 0;
        expect_st("idle_lap_ignored", enc(0), 1'b0, 1'b0, 1'b0, 6'b0);

        tap(B_SET | B_SS);
        expect_st("prio_set", enc(0), 1'b0, 1'b1, 1'b0, 6'b000001);
        repeat (6) tap(B_SET);
        expect_st("prio_exit", enc(0), 1'b0, 1'b0, 1'b0, 6'b0);

        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        if (n_pass != n_checks || sbq.size() != 0)
            $display("FAIL summary: got %0d/%0d passed with %0d pending, expected all passed and none pending",
                     n_pass, n_checks, sbq.size());
        $finish;
    end

endmodule
